// File: rtl/time_manager.sv
// time_manager
// Central scheduler for a set of emulated clock generators. It finds the
// earliest pending generator edge and broadcasts that time to all
// generators. Every generator whose next-edge time matches the broadcast
// fires in that cycle. One advance takes two system cycles:
//   EVAL    - capture the minimum of all generator times
//   ADVANCE - broadcast it on time_next
// Outside ADVANCE, time_next is held at all-ones (TIME_MAX). Generators never
// hold that value, so no generator can match it.
//
// Optional feature macro: TIME_MANAGER_STOP_EN
//   defined   - advancing halts once the captured minimum reaches stop_time
//   undefined - stop_time is ignored and halted is always 0
//
// Parameters
//   N_CLK           number of generators scheduled (1..8)
//   TIME_W          width of emulated time values
// Ports
//   clk_sys         system clock, rising-edge active
//   rst             asynchronous active-high reset
//   run             level, free-running advance while high
//   step            one-cycle pulse, requests a single advance from idle
//   stop_time       emulated time at which advancing halts
//   time_clock_flat next-edge time of each generator, gen k at [k*TIME_W +: TIME_W]
//   time_next       broadcast time (TIME_MAX when not advancing)
//   emu_time        last broadcast time
//   adv_count       number of completed advances, wraps at 2^32
//   busy            high while evaluating or advancing
//   halted          high while parked at the stop time
module time_manager #(
    parameter int N_CLK  = 2,
    parameter int TIME_W = 32
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    step,
    input  logic [TIME_W-1:0]       stop_time,
    input  logic [N_CLK*TIME_W-1:0] time_clock_flat,
    output logic [TIME_W-1:0]       time_next,
    output logic [TIME_W-1:0]       emu_time,
    output logic [31:0]             adv_count,
    output logic                    busy,
    output logic                    halted
);

    localparam logic [TIME_W-1:0] TIME_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        ADVANCE,
        HALT
    } state_t;

    state_t            state_q;
    logic [TIME_W-1:0] minTime_q;
    logic [TIME_W-1:0] minTime_d;
    logic [TIME_W-1:0] timeNext_q;
    logic [TIME_W-1:0] emuTime_q;
    logic [31:0]       advCount_q;
    logic              busy_q;
    logic              halted_q;
    logic              stopHit;

    // Unsigned minimum over all generator times. Equal times collapse to the
    // same value, so every tied generator fires on the same broadcast.
    always_comb begin
        minTime_d = time_clock_flat[0 +: TIME_W];
        for (int k = 1; k < N_CLK; k++) begin
            if (time_clock_flat[k*TIME_W +: TIME_W] < minTime_d) begin
                minTime_d = time_clock_flat[k*TIME_W +: TIME_W];
            end
        end
    end

    // The stop test uses the value that EVAL is capturing, not the old
    // minTime_q. This keeps a run from issuing one advance past stop_time.
`ifdef TIME_MANAGER_STOP_EN
    assign stopHit = (minTime_d >= stop_time);
`else
    logic unusedStopTime;
    assign unusedStopTime = ^stop_time;
    assign stopHit        = 1'b0;
`endif

    // Scheduler FSM. All outputs are registered and computed from the state
    // being entered. Because of this, an asynchronous reset drops time_next
    // back to TIME_MAX at once, even in the middle of an ADVANCE.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            minTime_q  <= '0;
            timeNext_q <= TIME_MAX;
            emuTime_q  <= '0;
            advCount_q <= '0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // When run and step arrive together, this behaves as
                    // run. Only run is checked on leaving ADVANCE.
                    if (run || step) begin
                        state_q <= EVAL;
                        busy_q  <= 1'b1;
                    end
                end
                EVAL: begin
                    minTime_q <= minTime_d;
                    if (stopHit) begin
                        state_q  <= HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state_q    <= ADVANCE;
                        timeNext_q <= minTime_d;
                    end
                end
                ADVANCE: begin
                    timeNext_q <= TIME_MAX;
                    emuTime_q  <= minTime_q;
                    advCount_q <= advCount_q + 32'd1;
                    // A step-started advance also returns to IDLE here, so
                    // a step during EVAL/ADVANCE is never queued.
                    if (run) begin
                        state_q <= EVAL;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                HALT: begin
                    // Leaving HALT needs both controls released, so a held
                    // run or a step pulse cannot restart past stop_time.
                    if (!run && !step) begin
                        state_q  <= IDLE;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    timeNext_q <= TIME_MAX;
                    busy_q     <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    assign time_next = timeNext_q;
    assign emu_time  = emuTime_q;
    assign adv_count = advCount_q;
    assign busy      = busy_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_time_manager.sv
// tb_time_manager
// Directed bench for time_manager with N_CLK=2 and TIME_W=32.
//
// Two small generator models drive time_clock_flat. Each generator can be:
//   - loaded with fixed times, or
//   - stepped by its period (gen0: 3, gen1: 5) whenever a broadcast matches
//     its current time.
// After a load, the generators ignore the first broadcast while they arm.
// In the free-running test, this makes both hold at 0 for one extra advance,
// which produces the leading 0,0 in the expected time sequence.
//
// Checking is scoreboard based:
//   - Stimulus pushes the expected {time, count after the advance}.
//   - A monitor pops an entry whenever time_next leaves TIME_MAX.
//   - The monitor checks the broadcast, then checks emu_time and adv_count
//     one cycle later.
module tb_time_manager;

    localparam int          N_CLK  = 2;
    localparam int          TIME_W = 32;
    localparam logic [31:0] TMAX   = 32'hFFFF_FFFF;

    logic                    clk_sys = 1'b0;
    logic                    rst     = 1'b1;
    logic                    run     = 1'b0;
    logic                    step    = 1'b0;
    logic [TIME_W-1:0]       stop_time = 32'd1000;
    logic [N_CLK*TIME_W-1:0] time_clock_flat;
    logic [TIME_W-1:0]       time_next;
    logic [TIME_W-1:0]       emu_time;
    logic [31:0]             adv_count;
    logic                    busy;
    logic                    halted;

    typedef struct {
        logic [31:0] t;
        logic [31:0] cnt;
    } exp_t;

    exp_t        expQ[$];
    int          checks  = 0;
    int          errors  = 0;
    int          advSeen = 0;

    logic [31:0] gen0;
    logic [31:0] gen1;
    logic [31:0] load0   = 32'd0;
    logic [31:0] load1   = 32'd0;
    logic        loadReq = 1'b1;
    logic        genRun  = 1'b0;
    logic        genArmed;

    time_manager #(
        .N_CLK (N_CLK),
        .TIME_W(TIME_W)
    ) dut (
        .clk_sys        (clk_sys),
        .rst            (rst),
        .run            (run),
        .step           (step),
        .stop_time      (stop_time),
        .time_clock_flat(time_clock_flat),
        .time_next      (time_next),
        .emu_time       (emu_time),
        .adv_count      (adv_count),
        .busy           (busy),
        .halted         (halted)
    );

    always #5 clk_sys = ~clk_sys;

    assign time_clock_flat = {gen1, gen0};

    // Generator models: load on request; otherwise step by their periods on
    // a matching broadcast, once they have armed on a first broadcast.
    always @(posedge clk_sys) begin
        if (loadReq) begin
            gen0     <= load0;
            gen1     <= load1;
            genArmed <= 1'b0;
        end else if (genRun && time_next != TMAX) begin
            genArmed <= 1'b1;
            if (genArmed && time_next == gen0) gen0 <= gen0 + 32'd3;
            if (genArmed && time_next == gen1) gen1 <= gen1 + 32'd5;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic failTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout, expected completion", name);
    endtask

    task automatic applyStimulus(input logic r, input logic s);
        @(negedge clk_sys);
        run  = r;
        step = s;
    endtask

    task automatic pushExp(input logic [31:0] t, input logic [31:0] cnt);
        exp_t e;
        e.t   = t;
        e.cnt = cnt;
        expQ.push_back(e);
    endtask

    task automatic loadGens(input logic [31:0] a, input logic [31:0] b, input logic free);
        @(negedge clk_sys);
        load0   = a;
        load1   = b;
        genRun  = free;
        loadReq = 1'b1;
        @(negedge clk_sys);
        loadReq = 1'b0;
    endtask

    task automatic waitAdvances(input int target, input int budget, input string name);
        int n = 0;
        while (advSeen < target && n < budget) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        if (advSeen < target) failTimeout(name);
    endtask

    task automatic waitDrain(input int budget, input string name);
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < budget) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        if (expQ.size() != 0 || busy) failTimeout(name);
    endtask

    // Monitor: a broadcast is any cycle where time_next differs from TIME_MAX.
    // It must occur while busy, last one cycle, and match the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_sys);
            if (!rst && time_next !== TMAX) begin
                advSeen++;
                checkOutput("busy_in_advance", {31'd0, busy}, 32'd1);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_advance: got time_next=%0d, expected no advance", time_next);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("time_next", time_next, e.t);
                    @(negedge clk_sys);
                    if (!rst) begin
                        checkOutput("emu_time_after_adv", emu_time, e.t);
                        checkOutput("adv_count_after_adv", adv_count, e.cnt);
                        checkOutput("time_next_one_cycle", time_next, TMAX);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;

        // Reset values, sampled while reset is held.
        repeat (2) @(negedge clk_sys);
        checkOutput("rst_time_next", time_next, TMAX);
        checkOutput("rst_emu_time", emu_time, 32'd0);
        checkOutput("rst_adv_count", adv_count, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        rst     = 1'b0;
        loadReq = 1'b0;
        repeat (2) @(negedge clk_sys);
        checkOutput("idle_after_rst", {31'd0, busy}, 32'd0);

        // A single step with tied generators gives one advance to 10.
        loadGens(32'd10, 32'd10, 1'b0);
        pushExp(32'd10, 32'd1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        waitDrain(20, "step_drain");
        checkOutput("step_adv_count", adv_count, 32'd1);
        checkOutput("step_emu_time", emu_time, 32'd10);
        checkOutput("step_idle", {31'd0, busy}, 32'd0);

        // Step held through EVAL and ADVANCE still produces only one advance.
        pushExp(32'd10, 32'd2);
        applyStimulus(1'b0, 1'b1);
        repeat (3) @(negedge clk_sys);
        step = 1'b0;
        waitDrain(20, "step_held_drain");
        checkOutput("step_held_count", adv_count, 32'd2);

        // Free-running generators (periods 3 and 5); run and step raised together.
        @(negedge clk_sys);
        rst = 1'b1;
        loadGens(32'd0, 32'd0, 1'b1);
        rst = 1'b0;
        checkOutput("rst2_adv_count", adv_count, 32'd0);
`ifdef TIME_MANAGER_STOP_EN
        stop_time = 32'd16;
        begin
            logic [31:0] seq[9] = '{0, 0, 3, 5, 6, 9, 10, 12, 15};
            for (int i = 0; i < 9; i++) pushExp(seq[i], i + 1);
        end
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        begin
            int n = 0;
            while (!halted && n < 200) begin
                @(negedge clk_sys);
                #1;
                n++;
            end
            if (!halted) failTimeout("halt_wait");
        end
        @(negedge clk_sys);
        #1;
        checkOutput("halt_flag", {31'd0, halted}, 32'd1);
        checkOutput("halt_adv_count", adv_count, 32'd9);
        checkOutput("halt_emu_time", emu_time, 32'd15);
        checkOutput("halt_not_busy", {31'd0, busy}, 32'd0);
        checkOutput("halt_queue_empty", expQ.size(), 32'd0);

        // Step pulses with run held keep the block parked.
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk_sys);
        checkOutput("halt_hold", {31'd0, halted}, 32'd1);
        checkOutput("halt_hold_count", adv_count, 32'd9);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk_sys);
        checkOutput("halt_release", {31'd0, halted}, 32'd0);

        // stop_time of 0 halts on the first EVAL with no advance.
        stop_time = 32'd0;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk_sys);
        checkOutput("stop0_halted", {31'd0, halted}, 32'd1);
        checkOutput("stop0_count", adv_count, 32'd9);
        @(negedge clk_sys);
        checkOutput("stop0_release", {31'd0, halted}, 32'd0);
`else
        stop_time = 32'd0;
        begin
            logic [31:0] seq[12] = '{0, 0, 3, 5, 6, 9, 10, 12, 15, 18, 20, 21};
            for (int i = 0; i < 12; i++) pushExp(seq[i], i + 1);
        end
        base = advSeen;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        waitAdvances(base + 12, 200, "run_adv_wait");
        run = 1'b0;
        waitDrain(20, "run_drain");
        checkOutput("run_adv_count", adv_count, 32'd12);
        checkOutput("run_emu_time", emu_time, 32'd21);
        checkOutput("run_never_halted", {31'd0, halted}, 32'd0);
`endif

        // Reset during an ADVANCE cycle clears everything at once.
        stop_time = 32'd1000;
        loadGens(32'd7, 32'd4, 1'b0);
        pushExp(32'd4, 32'd0);
        base = advSeen;
        applyStimulus(1'b1, 1'b0);
        waitAdvances(base + 1, 20, "rst_adv_wait");
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_time_next", time_next, TMAX);
        checkOutput("rst_mid_adv_count", adv_count, 32'd0);
        checkOutput("rst_mid_emu_time", emu_time, 32'd0);
        checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
        run = 1'b0;
        @(negedge clk_sys);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk_sys);
        checkOutput("post_rst_idle", {31'd0, busy}, 32'd0);
        checkOutput("post_rst_time_next", time_next, TMAX);
        checkOutput("final_queue_empty", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
